pl_sysref_gen: RTL and testbench

//  Programmable SYSREF pulse generator in the PL clock domain: the transmit-side

---
 rtl/pl_sysref_pkg.sv | 18 +
 rtl/pl_sysref_phase_cnt.sv | 26 ++
 rtl/pl_sysref_gen.sv | 167 ++++++++++++++++
 tb/tb_pl_sysref_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_sysref_pkg.sv
// Shared encodings for the PL SYSREF pulse generator: run modes and FSM states.
package pl_sysref_pkg;

    typedef enum logic [1:0] {
        SYSREF_OFF     = 2'd0,
        SYSREF_ONESHOT = 2'd1,
        SYSREF_BURST   = 2'd2,
        SYSREF_CONT    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/pl_sysref_phase_cnt.sv
// Loadable down-counter that saturates at zero; tc_o flags the last cycle of a phase.
module pl_sysref_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pl_sysref_gen.sv
// Programmable single/burst/continuous SYSREF pulse generator on pl_clk.
// The FSM runs one cycle ahead of the registered output stage.
module pl_sysref_gen
    import pl_sysref_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               pl_clk,
    input  logic               pl_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_count,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   high_cycles,
    input  logic [CNT_W-1:0]   delay,
    output logic               sysref_out,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    state_t             state_q;
    mode_t              mode_q;
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   high_q;
    logic [BURST_W-1:0] burst_q;
    logic               stop_pend_q;
    logic               fin_q;
    logic               sysref_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    logic               cfg_ok;
    logic               start_ok;
    logic               accept;
    logic               reject;
    logic               last_pulse;
    logic               stop_now;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_tc;

    assign cfg_ok = (mode != SYSREF_OFF) && (period >= CNT_W'(2)) &&
                    (high_cycles != '0) && (high_cycles < period) &&
                    !((mode == SYSREF_BURST) && (burst_count == '0));
    // busy_q also covers the cycle between entering IDLE and the done pulse
    assign start_ok   = (state_q == IDLE) && !busy_q && start && !stop;
    assign accept     = start_ok && cfg_ok;
    assign reject     = start_ok && !cfg_ok;
    assign last_pulse = (mode_q != SYSREF_CONT) && (burst_q == BURST_ONE);
    assign stop_now   = stop || stop_pend_q;

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                cnt_load = accept;
                cnt_val  = (delay == '0) ? (high_cycles - CNT_ONE) : (delay - CNT_ONE);
            end
            ARM: begin
                cnt_load = cnt_tc;
                cnt_val  = high_q - CNT_ONE;
            end
            HIGH: begin
                cnt_load = cnt_tc;
                cnt_val  = period_q - high_q - CNT_ONE;
            end
            default: begin
                cnt_load = cnt_tc;
                cnt_val  = high_q - CNT_ONE;
            end
        endcase
    end

    pl_sysref_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_i      (pl_clk),
        .rst_i      (pl_rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            state_q     <= IDLE;
            mode_q      <= SYSREF_OFF;
            period_q    <= '0;
            high_q      <= '0;
            burst_q     <= '0;
            stop_pend_q <= 1'b0;
            fin_q       <= 1'b0;
            sysref_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            sysref_q  <= (state_q == HIGH);
            done_q    <= fin_q;
            cfg_err_q <= reject;
            fin_q     <= 1'b0;
            if (fin_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mode_q      <= mode_t'(mode);
                        period_q    <= period;
                        high_q      <= high_cycles;
                        burst_q     <= (mode == SYSREF_BURST) ? burst_count : BURST_ONE;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (delay == '0) ? HIGH : ARM;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state_q <= IDLE;
                        fin_q   <= 1'b1;
                    end else if (cnt_tc) begin
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    // A stop seen mid-pulse is held so the pulse keeps its full width
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (cnt_tc) begin
                        if (stop_now || last_pulse) begin
                            state_q <= IDLE;
                            fin_q   <= 1'b1;
                        end else begin
                            state_q <= LOW;
                            if (mode_q != SYSREF_CONT) begin
                                burst_q <= burst_q - BURST_ONE;
                            end
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        state_q <= IDLE;
                        fin_q   <= 1'b1;
                    end else if (cnt_tc) begin
                        state_q <= HIGH;
                    end
                end
            endcase
        end
    end

    assign sysref_out = sysref_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pl_sysref_gen.sv
// Scoreboard bench for pl_sysref_gen: expected edge/done/cfg_err events per run.
module tb_pl_sysref_gen;

    localparam int EV_FALL = 0;
    localparam int EV_DONE = 1;
    localparam int EV_RISE = 2;
    localparam int EV_CFG  = 3;
    localparam int FOREVER_PULSES = 1 << 30;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic        pl_clk = 1'b0;
    logic        pl_rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  burst_count = 8'd0;
    logic [15:0] period = 16'd0;
    logic [15:0] high_cycles = 16'd0;
    logic [15:0] delay = 16'd0;
    logic        sysref_out;
    logic        busy;
    logic        done;
    logic        cfg_err;

    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic prev_s = 1'b0;
    logic prev_b = 1'b0;

    pl_sysref_gen #(
        .CNT_W   (16),
        .BURST_W (8)
    ) dut (
        .pl_clk      (pl_clk),
        .pl_rst      (pl_rst),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .burst_count (burst_count),
        .period      (period),
        .high_cycles (high_cycles),
        .delay       (delay),
        .sysref_out  (sysref_out),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 pl_clk = ~pl_clk;
    always @(posedge pl_clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            EV_FALL: return "fall";
            EV_DONE: return "done";
            EV_RISE: return "rise";
            default: return "cfg_err";
        endcase
    endfunction

    task automatic check(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(int kind, int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_%s: got event at cycle %0d, want none", kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            check({"event_kind_", kname(kind)}, kind, e.kind);
            check({"event_cycle_", kname(kind)}, cyc, e.at);
        end
    endtask

    // Monitor: turns output waveforms into events and checks them against the queue
    always @(negedge pl_clk) begin
        if (mon_en) begin
            if (prev_s && !sysref_out) observe(EV_FALL);
            if (done) begin
                observe(EV_DONE);
                check("busy_at_done", int'(busy), 0);
                check("busy_before_done", int'(prev_b), 1);
            end
            if (!prev_s && sysref_out) begin
                observe(EV_RISE);
                check("busy_at_rise", int'(busy), 1);
            end
            if (cfg_err) begin
                observe(EV_CFG);
                check("busy_at_cfg_err", int'(busy), 0);
            end
        end
        prev_s = sysref_out;
        prev_b = busy;
    end

    // Reference model: pulse k rises at E+1+delay+k*period and lasts high cycles.
    // A stop sampled at edge S ends the run at S+1 unless the output is high then,
    // in which case the pulse finishes and the run ends with its falling edge.
    task automatic model_run(int e0, int md, int nb, int p, int h, int d, int s);
        int n;
        int r;
        n = (md == 1) ? 1 : ((md == 2) ? nb : FOREVER_PULSES);
        for (int k = 0; k < n; k++) begin
            r = e0 + 1 + d + k * p;
            if (s >= 0 && s < r) begin
                push(EV_DONE, s + 1);
                return;
            end
            push(EV_RISE, r);
            push(EV_FALL, r + h);
            if ((s >= r && s < r + h) || k == n - 1) begin
                push(EV_DONE, r + h);
                return;
            end
        end
    endtask

    function automatic bit on_edge(int s, int r0, int p, int h, int n);
        for (int k = 0; k < n && r0 + k * p <= s; k++) begin
            if (s == r0 + k * p || s == r0 + k * p + h) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_drain(string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge pl_clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d events pending, want 0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge pl_clk);
    endtask

    // srel/xrel: stop / extra start sampled at edge E+rel (-1 for none)
    task automatic run(string tag, int md, int nb, int p, int h, int d, int srel, int xrel);
        int e0;
        int last;
        int xr;
        bit ok;
        @(negedge pl_clk);
        mode        = 2'(md);
        burst_count = 8'(nb);
        period      = 16'(p);
        high_cycles = 16'(h);
        delay       = 16'(d);
        start       = 1'b1;
        e0 = cyc + 1;
        xr = xrel;
        ok = (md != 0) && (p >= 2) && (h >= 1) && (h < p) && !(md == 2 && nb == 0);
        if (ok) begin
            model_run(e0, md, nb, p, h, d, (srel >= 0) ? e0 + srel : -1);
            if (xr > exp_q[$].at - e0) xr = -1;
        end else begin
            push(EV_CFG, e0);
            xr = -1;
        end
        $display("[TB] %s: mode=%0d burst=%0d period=%0d high=%0d delay=%0d start@%0d stop_rel=%0d xstart_rel=%0d valid=%0d",
                 tag, md, nb, p, h, d, e0, srel, xr, ok);
        @(negedge pl_clk);
        start       = 1'b0;
        mode        = 2'($urandom);
        burst_count = 8'($urandom);
        period      = 16'($urandom_range(0, 40));
        high_cycles = 16'($urandom_range(0, 40));
        delay       = 16'($urandom_range(0, 40));
        last = (srel > xr) ? srel : xr;
        while (cyc < e0 + last) begin
            start = (cyc + 1 == e0 + xr);
            stop  = (cyc + 1 == e0 + srel);
            @(negedge pl_clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        wait_drain(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int md, nb, p, h, d, srel, xrel, r0, n;

        repeat (3) @(negedge pl_clk);
        pl_rst = 1'b0;
        @(negedge pl_clk);
        check("reset_sysref", int'(sysref_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_cfg_err", int'(cfg_err), 0);
        mon_en = 1'b1;

        run("oneshot_10_3_0", 1, 0, 10, 3, 0, -1, -1);
        run("burst_4_8_2_5", 2, 4, 8, 2, 5, -1, -1);
        run("cont_stop_mid_high", 3, 0, 6, 4, 0, 9, -1);
        run("cfg_high_eq_period", 1, 0, 5, 5, 0, -1, -1);
        run("cfg_period_1", 1, 0, 1, 1, 0, -1, -1);
        run("cfg_mode_off", 0, 0, 10, 3, 0, -1, -1);
        run("cfg_burst_zero", 2, 0, 8, 2, 0, -1, -1);
        run("cfg_high_zero", 1, 0, 8, 0, 0, -1, -1);
        run("busy_start_and_arm_stop", 3, 0, 8, 3, 20, 5, 2);
        run("burst_max_255", 2, 255, 2, 1, 0, -1, -1);
        run("burst_extra_start", 2, 3, 5, 2, 1, -1, 4);

        // start together with stop in IDLE is ignored, even with a bad config
        @(negedge pl_clk);
        mode = 2'd0; period = 16'd1; high_cycles = 16'd0; start = 1'b1; stop = 1'b1;
        $display("[TB] start_with_stop: start and stop together at edge %0d", cyc + 1);
        @(negedge pl_clk);
        start = 1'b0; stop = 1'b0;
        check("start_stop_cfg_err", int'(cfg_err), 0);
        check("start_stop_busy", int'(busy), 0);
        wait_drain("start_with_stop");

        // Reset in the middle of a pulse
        mon_en = 1'b0;
        @(negedge pl_clk);
        mode = 2'd3; period = 16'd6; high_cycles = 16'd4; delay = 16'd0; start = 1'b1;
        $display("[TB] reset_mid_high: continuous start at edge %0d", cyc + 1);
        @(negedge pl_clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !sysref_out; i++) @(negedge pl_clk);
        check("rst_pulse_seen", int'(sysref_out), 1);
        @(negedge pl_clk);
        #2 pl_rst = 1'b1;
        #1;
        check("rst_async_sysref", int'(sysref_out), 0);
        check("rst_async_busy", int'(busy), 0);
        repeat (2) @(negedge pl_clk);
        pl_rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge pl_clk);
        run("after_reset_burst", 2, 2, 4, 1, 1, -1, -1);

        for (int t = 0; t < 25; t++) begin
            md = $urandom_range(1, 3);
            p  = $urandom_range(2, 12);
            h  = $urandom_range(1, p - 1);
            d  = $urandom_range(0, 6);
            nb = $urandom_range(1, 5);
            if (md == 3 && h < 2) begin
                p = $urandom_range(3, 12);
                h = $urandom_range(2, p - 1);
            end
            srel = -1;
            xrel = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : -1;
            if (md == 3 || (md == 2 && $urandom_range(0, 1) == 1)) begin
                r0 = 1 + d;
                n  = (md == 2) ? nb : FOREVER_PULSES;
                srel = $urandom_range(1, d + 1 + 2 * p);
                for (int g = 0; g < 64 && on_edge(srel, r0, p, h, n); g++) srel++;
                if (xrel == srel) xrel = -1;
            end
            case ($urandom_range(0, 7))
                0: h = p;
                1: p = 1;
                2: md = 0;
                default: ;
            endcase
            run($sformatf("random_%0d", t), md, nb, p, h, d, srel, xrel);
        end

        repeat (40) @(negedge pl_clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
